// File: rtl/matmul_tile_scheduler.sv
// Tile scheduler for a matmul engine: for each tile of a job it issues
// read starts to the activation/weight buffers, waits for both loads,
// fires the MAC array, waits for compute, then releases the buffers.
// Each wait state has a timeout that traps into ERROR until aborted.
module matmul_tile_scheduler #(
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [TILE_W-1:0] i_num_tiles,
  input  logic              i_abort,
  input  logic              i_a_done,
  input  logic              i_b_done,
  input  logic              i_mac_done,
  output logic              o_a_read_start,
  output logic              o_b_read_start,
  output logic              o_read_reset,
  output logic              o_mac_start,
  output logic [TILE_W-1:0] o_tile_idx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD      = 4'd1,
    WAIT_LOAD = 4'd2,
    COMPUTE   = 4'd3,
    WAIT_MAC  = 4'd4,
    RELEASE   = 4'd5,
    FINISH    = 4'd6,
    ABORT     = 4'd7,
    ERROR     = 4'd8
  } state_t;

  state_t            state, state_nxt;
  logic [TILE_W-1:0] num_tiles_q;
  logic [TILE_W-1:0] tile_idx;
  logic              a_seen, b_seen;
  logic [CNT_W-1:0]  wait_cnt;
  logic              load_ok, timeout_hit, last_tile;

  // A done seen this cycle counts together with the sticky flags, so the
  // move to COMPUTE happens in the cycle after the second load finishes.
  assign load_ok     = (a_seen || i_a_done) && (b_seen || i_b_done);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign last_tile   = (tile_idx == num_tiles_q - TILE_W'(1));
  assign o_tile_idx  = tile_idx;
  assign o_state     = state;

  // Next-state selection; abort outranks completion, completion outranks timeout.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:      if (i_start) state_nxt = (i_num_tiles != '0) ? LOAD : FINISH;
      LOAD:      state_nxt = WAIT_LOAD;
      WAIT_LOAD: if (load_ok) state_nxt = COMPUTE;
                 else if (timeout_hit) state_nxt = ERROR;
      COMPUTE:   state_nxt = WAIT_MAC;
      WAIT_MAC:  if (i_mac_done) state_nxt = RELEASE;
                 else if (timeout_hit) state_nxt = ERROR;
      RELEASE:   state_nxt = last_tile ? FINISH : LOAD;
      FINISH:    state_nxt = IDLE;
      ABORT:     state_nxt = IDLE;
      ERROR:     state_nxt = ERROR;
      default:   state_nxt = IDLE;
    endcase
    // ABORT itself is excluded so it always lasts exactly one cycle.
    if (i_abort && state != IDLE && state != ABORT) state_nxt = ABORT;
  end

  // State, job registers and Moore outputs registered from the next state.
  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset; every register here is a plain flop, so all get cleared.
    if (i_rst) begin
      state          <= IDLE;
      num_tiles_q    <= '0;
      tile_idx       <= '0;
      a_seen         <= 1'b0;
      b_seen         <= 1'b0;
      wait_cnt       <= '0;
      o_a_read_start <= 1'b0;
      o_b_read_start <= 1'b0;
      o_read_reset   <= 1'b0;
      o_mac_start    <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state <= state_nxt;
      case (state)
        IDLE: if (i_start) begin
          num_tiles_q <= i_num_tiles;
          tile_idx    <= '0;
        end
        LOAD: begin
          a_seen   <= 1'b0;
          b_seen   <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT_LOAD: begin
          a_seen   <= a_seen || i_a_done;
          b_seen   <= b_seen || i_b_done;
          wait_cnt <= wait_cnt + CNT_W'(1);
        end
        COMPUTE:  wait_cnt <= '0;
        WAIT_MAC: wait_cnt <= wait_cnt + CNT_W'(1);
        RELEASE:  if (state_nxt == LOAD) tile_idx <= tile_idx + TILE_W'(1);
        default:  ;
      endcase
      o_a_read_start <= (state_nxt == LOAD);
      o_b_read_start <= (state_nxt == LOAD);
      o_mac_start    <= (state_nxt == COMPUTE);
      o_read_reset   <= (state_nxt == RELEASE) || (state_nxt == ABORT);
      o_done         <= (state_nxt == FINISH);
      o_err          <= (state_nxt == ERROR);
      o_busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Self-checking bench for matmul_tile_scheduler: randomized jobs checked
// cycle by cycle against a timeline built from the scheduling rules, plus
// directed timeout, abort, zero-tile and reset scenarios.
module tb_matmul_tile_scheduler;
  localparam int TW = 8;

  localparam int S_IDLE = 0, S_LOAD = 1, S_WAIT_LOAD = 2, S_COMPUTE = 3,
                 S_WAIT_MAC = 4, S_RELEASE = 5, S_FINISH = 6, S_ABORT = 7,
                 S_ERROR = 8;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [TW-1:0] i_num_tiles = '0;
  logic          i_abort = 1'b0;
  logic          i_a_done = 1'b0;
  logic          i_b_done = 1'b0;
  logic          i_mac_done = 1'b0;
  logic          o_a_read_start, o_b_read_start, o_read_reset, o_mac_start;
  logic [TW-1:0] o_tile_idx;
  logic          o_busy, o_done, o_err;
  logic [3:0]    o_state;

  matmul_tile_scheduler #(.TILE_W(TW), .TIMEOUT(64), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_tiles(i_num_tiles),
    .i_abort(i_abort), .i_a_done(i_a_done), .i_b_done(i_b_done),
    .i_mac_done(i_mac_done), .o_a_read_start(o_a_read_start),
    .o_b_read_start(o_b_read_start), .o_read_reset(o_read_reset),
    .o_mac_start(o_mac_start), .o_tile_idx(o_tile_idx), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Expected timeline: one entry per cycle with the state the DUT must be in
  // and the inputs to drive during that cycle.
  int q_st[$], q_idx[$], q_n[$];
  bit q_a[$], q_b[$], q_m[$], q_s[$];
  int da[8], db[8], dm[8];
  int cnt_a, cnt_b, cnt_mac, cnt_rr, cnt_done, done_at, comp_at;

  function automatic bit coin();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic add(int st, int idx, bit a, bit b, bit m, bit s, int n);
    q_st.push_back(st); q_idx.push_back(idx); q_a.push_back(a);
    q_b.push_back(b);   q_m.push_back(m);     q_s.push_back(s);
    q_n.push_back(n);
  endtask

  // Tile k: LOAD, then WAIT_LOAD until the later done (inclusive), COMPUTE,
  // WAIT_MAC until mac_done (inclusive), RELEASE. Spurious i_start and
  // out-of-window i_mac_done are sprinkled in and must be ignored.
  task automatic plan_job(int n);
    int w;
    q_st.delete(); q_idx.delete(); q_a.delete(); q_b.delete();
    q_m.delete();  q_s.delete();   q_n.delete();
    add(S_IDLE, -1, 0, 0, 0, 1, n);
    if (n == 0) begin
      add(S_FINISH, -1, 0, 0, 0, 0, 0);
      add(S_IDLE, -1, 0, 0, 0, 0, 0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      add(S_LOAD, k, 0, 0, coin(), coin(), $urandom_range(0, 255));
      w = (da[k] > db[k]) ? da[k] : db[k];
      for (int j = 0; j <= w; j++)
        add(S_WAIT_LOAD, k, j == da[k], j == db[k], coin(), coin(), $urandom_range(0, 255));
      add(S_COMPUTE, k, 0, 0, coin(), coin(), $urandom_range(0, 255));
      for (int j = 0; j <= dm[k]; j++)
        add(S_WAIT_MAC, k, 0, 0, j == dm[k], coin(), $urandom_range(0, 255));
      add(S_RELEASE, k, 0, 0, coin(), coin(), $urandom_range(0, 255));
    end
    add(S_FINISH, n - 1, 0, 0, coin(), coin(), $urandom_range(0, 255));
    add(S_IDLE, n - 1, 0, 0, 0, 0, 0);
  endtask

  task automatic execute(string tag);
    cnt_a = 0; cnt_b = 0; cnt_mac = 0; cnt_rr = 0; cnt_done = 0;
    done_at = -1; comp_at = -1;
    for (int i = 0; i < q_st.size(); i++) begin
      i_start = q_s[i]; i_num_tiles = TW'(q_n[i]);
      i_a_done = q_a[i]; i_b_done = q_b[i]; i_mac_done = q_m[i];
      check({tag, "_state"}, 32'(o_state), 32'(q_st[i]));
      if (q_idx[i] >= 0) check({tag, "_idx"}, 32'(o_tile_idx), 32'(q_idx[i]));
      check({tag, "_a_rd"}, 32'(o_a_read_start), 32'(q_st[i] == S_LOAD));
      check({tag, "_b_rd"}, 32'(o_b_read_start), 32'(q_st[i] == S_LOAD));
      check({tag, "_mac"}, 32'(o_mac_start), 32'(q_st[i] == S_COMPUTE));
      check({tag, "_rr"}, 32'(o_read_reset), 32'(q_st[i] == S_RELEASE));
      check({tag, "_done"}, 32'(o_done), 32'(q_st[i] == S_FINISH));
      check({tag, "_busy"}, 32'(o_busy), 32'(q_st[i] != S_IDLE));
      check({tag, "_err"}, 32'(o_err), 32'd0);
      cnt_a += int'(o_a_read_start); cnt_b += int'(o_b_read_start);
      cnt_mac += int'(o_mac_start);  cnt_rr += int'(o_read_reset);
      cnt_done += int'(o_done);
      if (o_done === 1'b1 && done_at < 0) done_at = i;
      if (o_mac_start === 1'b1 && comp_at < 0) comp_at = i;
      tick();
    end
    i_start = 0; i_a_done = 0; i_b_done = 0; i_mac_done = 0; i_num_tiles = '0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_state"}, 32'(o_state), 32'd0);
    check({tag, "_idx"}, 32'(o_tile_idx), 32'd0);
    check({tag, "_pulses"}, 32'({o_a_read_start, o_b_read_start, o_read_reset,
                                 o_mac_start, o_busy, o_done, o_err}), 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) tick();
    check_all_zero("reset");
    i_rst = 0;
    tick();

    // Single tile reference timing: dones at 15, mac_done at 20
    da[0] = 13; db[0] = 13; dm[0] = 3;
    plan_job(1);
    execute("single");
    check("single_compute_cycle", 32'(comp_at), 32'd16);
    check("single_done_cycle", 32'(done_at), 32'd22);

    // Three tiles with random delays
    for (int k = 0; k < 3; k++) begin
      da[k] = $urandom_range(0, 20); db[k] = $urandom_range(0, 20);
      dm[k] = $urandom_range(0, 12);
    end
    plan_job(3);
    execute("three");
    check("three_a_starts", 32'(cnt_a), 32'd3);
    check("three_b_starts", 32'(cnt_b), 32'd3);
    check("three_mac_starts", 32'(cnt_mac), 32'd3);
    check("three_read_resets", 32'(cnt_rr), 32'd3);
    check("three_done", 32'(cnt_done), 32'd1);

    // Skewed single-cycle done pulses
    da[0] = 3; db[0] = 9; dm[0] = 2;
    plan_job(1);
    execute("skew");

    // Completion in the last cycle before timeout wins over the timeout
    da[0] = 63; db[0] = 5; dm[0] = 63;
    plan_job(1);
    execute("edge");

    // Random jobs
    repeat (4) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        da[k] = $urandom_range(0, 20); db[k] = $urandom_range(0, 20);
        dm[k] = $urandom_range(0, 12);
      end
      plan_job(n);
      execute("rand");
    end

    // Zero tiles: FINISH next cycle, no read starts
    plan_job(0);
    execute("zero");
    check("zero_a_starts", 32'(cnt_a), 32'd0);
    check("zero_done", 32'(cnt_done), 32'd1);

    // Timeout in WAIT_LOAD, then abort out of ERROR
    i_num_tiles = 1; i_start = 1;
    tick();
    i_start = 0;
    check("to_load", 32'(o_state), 32'(S_LOAD));
    tick();
    check("to_wait", 32'(o_state), 32'(S_WAIT_LOAD));
    i_a_done = 1;
    n = 0;
    while (o_state !== 4'(S_ERROR) && n < 200) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd64);
    i_a_done = 0;
    repeat (3) begin
      tick();
      check("err_state", 32'(o_state), 32'(S_ERROR));
      check("err_flag", 32'(o_err), 32'd1);
      check("err_pulses", 32'({o_a_read_start, o_b_read_start, o_mac_start,
                               o_read_reset, o_done}), 32'd0);
    end
    i_abort = 1;
    tick();
    i_abort = 0;
    check("err_abort_state", 32'(o_state), 32'(S_ABORT));
    check("err_abort_rr", 32'(o_read_reset), 32'd1);
    check("err_abort_done", 32'(o_done), 32'd0);
    tick();
    check("err_abort_idle", 32'(o_state), 32'(S_IDLE));
    check("err_abort_err", 32'(o_err), 32'd0);

    // Abort during WAIT_MAC
    i_num_tiles = 2; i_start = 1;
    tick();
    i_start = 0;
    tick();
    i_a_done = 1; i_b_done = 1;
    tick();
    i_a_done = 0; i_b_done = 0;
    check("ab_compute", 32'(o_state), 32'(S_COMPUTE));
    tick();
    check("ab_wait_mac", 32'(o_state), 32'(S_WAIT_MAC));
    i_abort = 1;
    tick();
    i_abort = 0;
    check("ab_abort", 32'(o_state), 32'(S_ABORT));
    check("ab_rr", 32'(o_read_reset), 32'd1);
    check("ab_done", 32'(o_done), 32'd0);
    tick();
    check("ab_idle", 32'(o_state), 32'(S_IDLE));
    check("ab_idle_done", 32'(o_done), 32'd0);

    // Reset mid-job in WAIT_LOAD of tile 2, with i_start held while busy
    i_num_tiles = 4; i_start = 1;
    tick();
    i_num_tiles = 1;
    n = 0;
    while (!(o_state === 4'(S_WAIT_LOAD) && o_tile_idx === 8'd2) && n < 200) begin
      i_a_done   = (o_state === 4'(S_WAIT_LOAD));
      i_b_done   = (o_state === 4'(S_WAIT_LOAD));
      i_mac_done = (o_state === 4'(S_WAIT_MAC));
      tick();
      n++;
    end
    i_a_done = 0; i_b_done = 0; i_mac_done = 0;
    check("rst_reach_state", 32'(o_state), 32'(S_WAIT_LOAD));
    check("rst_reach_idx", 32'(o_tile_idx), 32'd2);
    i_start = 0; i_rst = 1;
    tick();
    i_rst = 0;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_hold");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
